// File: rtl/gfx_clip_zcmp.sv
// Scissor/target clip and depth test for one pixel at a time; discard acks 1 cycle after sampling, z path reads (and optionally writes) the z-buffer.
// Backpressure: write_i is taken only in IDLE with ack_o low; z/zw requests and write_o hold until their acks.
module gfx_clip_zcmp #(
   parameter int point_width = 16,
   parameter int ZW          = 16,
   parameter int NCLIP       = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NCLIP-1:0]             clipping_enable_i,
   input  logic [NCLIP*point_width-1:0] clip_x0_i,
   input  logic [NCLIP*point_width-1:0] clip_y0_i,
   input  logic [NCLIP*point_width-1:0] clip_x1_i,
   input  logic [NCLIP*point_width-1:0] clip_y1_i,
   input  logic [point_width-1:0]       target_size_x_i,
   input  logic [point_width-1:0]       target_size_y_i,
   input  logic                         zbuffer_enable_i,
   input  logic                         zwrite_enable_i,
   input  logic [2:0]                   zfunc_i,
   input  logic [31:0]                  zbuffer_base_i,
   input  logic [point_width-1:0]       pixel_x_i,
   input  logic [point_width-1:0]       pixel_y_i,
   input  logic [ZW-1:0]                pixel_z_i,
   input  logic [point_width-1:0]       u_i,
   input  logic [point_width-1:0]       v_i,
   input  logic [7:0]                   a_i,
   input  logic [31:0]                  color_i,
   input  logic                         write_i,
   output logic                         ack_o,
   output logic                         z_request_o,
   output logic [31:0]                  z_addr_o,
   input  logic [ZW-1:0]                z_data_i,
   input  logic                         z_ack_i,
   output logic                         zw_request_o,
   output logic [31:0]                  zw_addr_o,
   output logic [ZW-1:0]                zw_data_o,
   input  logic                         zw_ack_i,
   output logic [point_width-1:0]       pixel_x_o,
   output logic [point_width-1:0]       pixel_y_o,
   output logic [point_width-1:0]       u_o,
   output logic [point_width-1:0]       v_o,
   output logic [ZW-1:0]                pixel_z_o,
   output logic [7:0]                   a_o,
   output logic [31:0]                  color_o,
   output logic                         write_o,
   input  logic                         ack_i
);

   localparam logic [31:0] ZBYTES = 32'(ZW / 8);

   typedef enum logic [2:0] {IDLE, ADDR, ZREAD, ZTEST, ZWRITE, OUT} state_t;

   state_t               state_q, state_d;
   logic                 ack_d, write_d, zreq_d, zwreq_d;
   logic                 latch, ld_addr, cap_z;
   logic                 discard, zpass;
   logic signed [ZW-1:0] zstored_q;
   logic [31:0]          lin_addr, zaddr_calc;

   always_comb begin
      discard = (pixel_x_i >= target_size_x_i) || (pixel_y_i >= target_size_y_i);
      for (int r = 0; r < NCLIP; r++) begin
         if (clipping_enable_i[r] &&
             ((pixel_x_i <  clip_x0_i[r*point_width +: point_width]) ||
              (pixel_y_i <  clip_y0_i[r*point_width +: point_width]) ||
              (pixel_x_i >= clip_x1_i[r*point_width +: point_width]) ||
              (pixel_y_i >= clip_y1_i[r*point_width +: point_width])))
            discard = 1'b1;
      end
   end

   // New depth on the left, stored depth on the right, both two's complement.
   always_comb begin
      case (zfunc_i)
         3'd0:    zpass = 1'b0;
         3'd1:    zpass = $signed(pixel_z_o) <  zstored_q;
         3'd2:    zpass = $signed(pixel_z_o) == zstored_q;
         3'd3:    zpass = $signed(pixel_z_o) <= zstored_q;
         3'd4:    zpass = $signed(pixel_z_o) >  zstored_q;
         3'd5:    zpass = $signed(pixel_z_o) != zstored_q;
         3'd6:    zpass = $signed(pixel_z_o) >= zstored_q;
         default: zpass = 1'b1;
      endcase
   end

   assign lin_addr   = 32'(pixel_y_o) * 32'(target_size_x_i) + 32'(pixel_x_o);
   assign zaddr_calc = zbuffer_base_i + lin_addr * ZBYTES;
   assign zw_data_o  = pixel_z_o;

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      write_d = write_o;
      zreq_d  = z_request_o;
      zwreq_d = zw_request_o;
      latch   = 1'b0;
      ld_addr = 1'b0;
      cap_z   = 1'b0;
      case (state_q)
         IDLE: begin
            // Holding off while ack_o is high keeps a held write_i from being retaken.
            if (write_i && !ack_o) begin
               latch = 1'b1;
               if (discard) begin
                  ack_d = 1'b1;
               end else if (zbuffer_enable_i) begin
                  state_d = ADDR;
               end else begin
                  write_d = 1'b1;
                  state_d = OUT;
               end
            end
         end
         ADDR: begin
            ld_addr = 1'b1;
            zreq_d  = 1'b1;
            state_d = ZREAD;
         end
         ZREAD: begin
            if (z_ack_i) begin
               cap_z   = 1'b1;
               zreq_d  = 1'b0;
               state_d = ZTEST;
            end
         end
         ZTEST: begin
            if (!zpass) begin
               ack_d   = 1'b1;
               state_d = IDLE;
            end else if (zwrite_enable_i) begin
               zwreq_d = 1'b1;
               state_d = ZWRITE;
            end else begin
               write_d = 1'b1;
               state_d = OUT;
            end
         end
         ZWRITE: begin
            if (zw_ack_i) begin
               zwreq_d = 1'b0;
               write_d = 1'b1;
               state_d = OUT;
            end
         end
         OUT: begin
            if (ack_i) begin
               write_d = 1'b0;
               ack_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         ack_o        <= 1'b0;
         write_o      <= 1'b0;
         z_request_o  <= 1'b0;
         zw_request_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         ack_o        <= ack_d;
         write_o      <= write_d;
         z_request_o  <= zreq_d;
         zw_request_o <= zwreq_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pixel_x_o <= '0;
         pixel_y_o <= '0;
         pixel_z_o <= '0;
         u_o       <= '0;
         v_o       <= '0;
         a_o       <= '0;
         color_o   <= '0;
         z_addr_o  <= '0;
         zw_addr_o <= '0;
         zstored_q <= '0;
      end else begin
         if (latch) begin
            pixel_x_o <= pixel_x_i;
            pixel_y_o <= pixel_y_i;
            pixel_z_o <= pixel_z_i;
            u_o       <= u_i;
            v_o       <= v_i;
            a_o       <= a_i;
            color_o   <= color_i;
         end
         if (ld_addr) begin
            z_addr_o  <= zaddr_calc;
            zw_addr_o <= zaddr_calc;
         end
         if (cap_z)
            zstored_q <= $signed(z_data_i);
      end
   end

endmodule

// File: tb/tb_gfx_clip_zcmp.sv
// Scoreboard bench for gfx_clip_zcmp: a reference model predicts each pixel's fate, a monitor checks DUT events.
module tb_gfx_clip_zcmp;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  clipping_enable_i;
   logic [31:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
   logic [15:0] target_size_x_i, target_size_y_i;
   logic        zbuffer_enable_i, zwrite_enable_i;
   logic [2:0]  zfunc_i;
   logic [31:0] zbuffer_base_i;
   logic [15:0] pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i;
   logic [7:0]  a_i;
   logic [31:0] color_i;
   logic        write_i;
   logic        ack_o;
   logic        z_request_o;
   logic [31:0] z_addr_o;
   logic [15:0] z_data_i;
   logic        z_ack_i;
   logic        zw_request_o;
   logic [31:0] zw_addr_o;
   logic [15:0] zw_data_o;
   logic        zw_ack_i;
   logic [15:0] pixel_x_o, pixel_y_o, u_o, v_o, pixel_z_o;
   logic [7:0]  a_o;
   logic [31:0] color_o;
   logic        write_o;
   logic        ack_i;

   gfx_clip_zcmp #(.point_width(16), .ZW(16), .NCLIP(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .clipping_enable_i(clipping_enable_i),
      .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i), .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
      .target_size_x_i(target_size_x_i), .target_size_y_i(target_size_y_i),
      .zbuffer_enable_i(zbuffer_enable_i), .zwrite_enable_i(zwrite_enable_i),
      .zfunc_i(zfunc_i), .zbuffer_base_i(zbuffer_base_i),
      .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
      .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i), .write_i(write_i),
      .ack_o(ack_o),
      .z_request_o(z_request_o), .z_addr_o(z_addr_o), .z_data_i(z_data_i), .z_ack_i(z_ack_i),
      .zw_request_o(zw_request_o), .zw_addr_o(zw_addr_o), .zw_data_o(zw_data_o), .zw_ack_i(zw_ack_i),
      .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .u_o(u_o), .v_o(v_o),
      .pixel_z_o(pixel_z_o), .a_o(a_o), .color_o(color_o),
      .write_o(write_o), .ack_i(ack_i)
   );

   initial forever #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int          kind;   // 0 clipped, 1 depth fail, 2 forwarded
      bit          zr, zw;
      logic [31:0] zaddr;
      logic [15:0] x, y, z, u, v;
      logic [7:0]  a;
      logic [31:0] color;
      int          samp;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] zmem [logic [31:0]];
   int          checks = 0, fails = 0;
   int          zr_dly = 0, zw_dly = 0, fr_dly = 0;
   int          ack_cnt = 0, fwd_cnt = 0;
   logic [31:0] last_zaddr = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic logic [15:0] mem_rd(input logic [31:0] ad);
      return zmem.exists(ad) ? zmem[ad] : 16'h0000;
   endfunction

   // Depth read port: ack after zr_dly extra cycles of request.
   initial begin
      int c = 0;
      z_ack_i = 1'b0; z_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         if (z_request_o) begin
            if (c == zr_dly) begin z_ack_i = 1'b1; z_data_i = mem_rd(z_addr_o); end
            else z_ack_i = 1'b0;
            c++;
         end else begin
            z_ack_i = 1'b0; c = 0;
         end
      end
   end

   initial begin
      int c = 0;
      zw_ack_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (zw_request_o) begin
            if (c == zw_dly) begin zw_ack_i = 1'b1; zmem[zw_addr_o] = zw_data_o; end
            else zw_ack_i = 1'b0;
            c++;
         end else begin
            zw_ack_i = 1'b0; c = 0;
         end
      end
   end

   initial begin
      int c = 0;
      ack_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (write_o) begin
            ack_i = (c == fr_dly);
            c++;
         end else begin
            ack_i = 1'b0; c = 0;
         end
      end
   end

   // Monitor
   initial begin
      bit   p_zr = 0, p_zw = 0, p_wr = 0, p_ack = 0;
      bit   s_zr = 0, s_zw = 0, s_wr = 0, have;
      int   zack_c = 0, zwack_c = 0, fack_c = 0, zw_len = 0, lat;
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            p_zr = 0; p_zw = 0; p_wr = 0; p_ack = 0; s_zr = 0; s_zw = 0; s_wr = 0;
         end else begin
            have = (exp_q.size() > 0);
            if (have) e = exp_q[0];
            if (z_request_o && !p_zr) begin
               s_zr = 1; last_zaddr = z_addr_o;
               chk("zreq_expected", {63'd0, have && e.zr}, 64'd1);
               if (have) begin
                  chk("zreq_latency", cyc, e.samp + 1);
                  chk("z_addr", z_addr_o, e.zaddr);
               end
            end
            if (z_request_o && z_ack_i) zack_c = cyc;
            if (zw_request_o && !p_zw) begin
               s_zw = 1; zw_len = 0;
               chk("zwreq_expected", {63'd0, have && e.zw}, 64'd1);
               if (have) begin
                  chk("zwreq_latency", cyc, zack_c + 2);
                  chk("zw_addr", zw_addr_o, e.zaddr);
                  chk("zw_data", zw_data_o, e.z);
               end
            end
            if (zw_request_o) begin
               zw_len++;
               if (zw_ack_i) begin
                  chk("zw_hold_len", zw_len, zw_dly + 1);
                  zwack_c = cyc;
               end
            end
            if (write_o && !p_wr) begin
               s_wr = 1; fwd_cnt++;
               chk("write_expected", {63'd0, have && e.kind == 2}, 64'd1);
               if (have) begin
                  lat = !e.zr ? e.samp : (e.zw ? zwack_c + 1 : zack_c + 2);
                  chk("write_latency", cyc, lat);
                  chk("out_xy", {pixel_x_o, pixel_y_o}, {e.x, e.y});
                  chk("out_uv", {u_o, v_o}, {e.u, e.v});
                  chk("out_z_a", {pixel_z_o, a_o}, {e.z, e.a});
                  chk("out_color", color_o, e.color);
               end
            end
            if (write_o && ack_i) fack_c = cyc;
            if (ack_o) begin
               ack_cnt++;
               chk("ack_gap", {63'd0, p_ack}, 64'd0);
               chk("ack_expected", {63'd0, have}, 64'd1);
               if (have) begin
                  lat = (e.kind == 0) ? e.samp : (e.kind == 1 ? zack_c + 2 : fack_c + 1);
                  chk("ack_latency", cyc, lat);
                  chk("saw_write", {63'd0, s_wr}, {63'd0, e.kind == 2});
                  chk("saw_zread", {63'd0, s_zr}, {63'd0, e.zr});
                  chk("saw_zwrite", {63'd0, s_zw}, {63'd0, e.zw});
                  void'(exp_q.pop_front());
               end
               s_zr = 0; s_zw = 0; s_wr = 0;
            end
            p_zr = z_request_o; p_zw = zw_request_o; p_wr = write_o; p_ack = ack_o;
         end
      end
   end

   // Reference model: predicts the pixel's fate from the current configuration and z-buffer contents.
   function automatic exp_t model(input int x, input int y, input int z, input bit zen, input bit zwen, input int zf);
      exp_t  e;
      bit    disc;
      int    nz, sz;
      bit    pass;
      longint la;
      e.x = 16'(x); e.y = 16'(y); e.z = 16'(z);
      e.zr = 0; e.zw = 0;
      disc = (x >= int'(target_size_x_i)) || (y >= int'(target_size_y_i));
      for (int r = 0; r < 2; r++)
         if (clipping_enable_i[r] &&
             !(x >= int'(clip_x0_i[r*16 +: 16]) && x < int'(clip_x1_i[r*16 +: 16]) &&
               y >= int'(clip_y0_i[r*16 +: 16]) && y < int'(clip_y1_i[r*16 +: 16])))
            disc = 1;
      la = longint'(zbuffer_base_i) + (longint'(y) * longint'(target_size_x_i) + longint'(x)) * 2;
      e.zaddr = la[31:0];
      if (disc) e.kind = 0;
      else if (!zen) e.kind = 2;
      else begin
         e.zr = 1;
         nz = $signed(e.z);
         sz = $signed(mem_rd(e.zaddr));
         case (zf)
            0: pass = 0;
            1: pass = nz < sz;
            2: pass = nz == sz;
            3: pass = nz <= sz;
            4: pass = nz > sz;
            5: pass = nz != sz;
            6: pass = nz >= sz;
            default: pass = 1;
         endcase
         e.kind = pass ? 2 : 1;
         e.zw = pass && zwen;
      end
      return e;
   endfunction

   task automatic reset_pulse();
      rst_i = 1'b1; write_i = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   // Called at posedge+#1 with the DUT idle; returns at posedge+#1 after the pixel retired.
   task automatic issue(input int x, input int y, input int z, input bit zen, input bit zwen, input int zf);
      exp_t e;
      bit   got = 0;
      pixel_x_i = 16'(x); pixel_y_i = 16'(y); pixel_z_i = 16'(z);
      u_i = 16'($urandom); v_i = 16'($urandom); a_i = 8'($urandom); color_i = $urandom;
      zbuffer_enable_i = zen; zwrite_enable_i = zwen; zfunc_i = 3'(zf);
      write_i = 1'b1;
      e = model(x, y, z, zen, zwen, zf);
      e.u = u_i; e.v = v_i; e.a = a_i; e.color = color_i;
      @(posedge clk_i); #1;
      e.samp = cyc;
      exp_q.push_back(e);
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk_i);
         if (ack_o) got = 1;
      end
      chk("ack_arrived", {63'd0, got}, 64'd1);
      @(posedge clk_i); #1;
      write_i = 1'b0;
      if (!got) reset_pulse();
   endtask

   task automatic set_rect(input int r, input int x0, input int y0, input int x1, input int y1);
      clip_x0_i[r*16 +: 16] = 16'(x0); clip_y0_i[r*16 +: 16] = 16'(y0);
      clip_x1_i[r*16 +: 16] = 16'(x1); clip_y1_i[r*16 +: 16] = 16'(y1);
   endtask

   initial begin
      int f0, a0;
      bit got;
      rst_i = 1'b1; write_i = 1'b0;
      clipping_enable_i = '0; clip_x0_i = '0; clip_y0_i = '0; clip_x1_i = '0; clip_y1_i = '0;
      target_size_x_i = 16'd640; target_size_y_i = 16'd480;
      zbuffer_enable_i = 0; zwrite_enable_i = 0; zfunc_i = '0; zbuffer_base_i = '0;
      pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; u_i = '0; v_i = '0; a_i = '0; color_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_flags", {60'd0, write_o, ack_o, z_request_o, zw_request_o}, 64'd0);
      chk("rst_addrs", {z_addr_o, zw_addr_o}, 64'd0);
      chk("rst_pix", {pixel_x_o, pixel_y_o, pixel_z_o, u_o}, 64'd0);
      chk("rst_attr", {v_o, a_o, color_o, zw_data_o[7:0]}, 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // Target edge and just outside
      issue(639, 479, 0, 0, 0, 0);
      issue(640, 0, 0, 0, 0, 0);

      // Scissor rectangles
      set_rect(0, 10, 10, 20, 20); set_rect(1, 0, 0, 15, 15);
      clipping_enable_i = 2'b01;
      issue(20, 15, 0, 0, 0, 0);
      issue(19, 19, 0, 0, 0, 0);
      clipping_enable_i = 2'b11;
      issue(19, 19, 0, 0, 0, 0);
      clipping_enable_i = 2'b00;

      // Depth test, less-than, against stored 7 then 5
      zbuffer_base_i = 32'h1000;
      zmem[32'h1A06] = 16'd7;
      issue(3, 2, 5, 1, 0, 1);
      chk("zaddr_1A06", last_zaddr, 32'h0000_1A06);
      zmem[32'h1A06] = 16'd5;
      issue(3, 2, 5, 1, 0, 1);

      // Compare-function sweep, new=-3 stored=2
      zmem[32'h1A06] = 16'd2;
      f0 = fwd_cnt;
      for (int f = 0; f < 8; f++) issue(3, 2, -3, 1, 0, f);
      chk("sweep_pass_count", fwd_cnt - f0, 4);

      // Depth write with a held request
      zw_dly = 3;
      issue(5, 5, 100, 1, 1, 7);
      chk("zmem_written", mem_rd(32'h1000 + (5 * 640 + 5) * 2), 16'd100);
      zw_dly = 0;

      // Reset while the read is outstanding
      zr_dly = 40;
      begin
         exp_t e;
         pixel_x_i = 16'd1; pixel_y_i = 16'd1; pixel_z_i = 16'd1;
         zbuffer_enable_i = 1; zwrite_enable_i = 0; zfunc_i = 3'd7;
         e = model(1, 1, 1, 1, 0, 7);
         e.u = u_i; e.v = v_i; e.a = a_i; e.color = color_i;
         write_i = 1'b1;
         @(posedge clk_i); #1;
         e.samp = cyc;
         exp_q.push_back(e);
      end
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk_i);
         if (z_request_o) got = 1;
      end
      chk("rst_test_zreq_seen", {63'd0, got}, 64'd1);
      @(posedge clk_i); #2;
      rst_i = 1'b1; write_i = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_zreq_drop", {62'd0, z_request_o, ack_o}, 64'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      a0 = ack_cnt;
      zr_dly = 0;
      repeat (6) @(posedge clk_i);
      #1;
      chk("no_ack_after_rst", ack_cnt, a0);
      issue(2, 2, 3, 1, 0, 7);

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         int x, y;
         set_rect(0, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(10, 50), $urandom_range(10, 50));
         set_rect(1, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(10, 50), $urandom_range(10, 50));
         clipping_enable_i = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         target_size_x_i = ($urandom_range(0, 3) == 0) ? 16'd40 : 16'd640;
         target_size_y_i = 16'd480;
         zbuffer_base_i = {16'($urandom), 15'($urandom), 1'b0};
         zr_dly = $urandom_range(0, 3); zw_dly = $urandom_range(0, 3); fr_dly = $urandom_range(0, 3);
         x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 700) : $urandom_range(0, 45);
         y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 520) : $urandom_range(0, 45);
         issue(x, y, $urandom_range(0, 8) - 4, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 7));
      end

      repeat (4) @(posedge clk_i);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
